// File: rtl/soc_system_pio_ctrl.sv
// Avalon-MM parallel I/O port: output data, synchronised inputs, edge capture, irq.
// Optional OUTSET/OUTCLR bit-set registers enabled by defining PIO_BITSET_EN.
module soc_system_pio_ctrl #(
  parameter int unsigned WIDTH       = 8,
  parameter logic [31:0] RESET_VALUE = 32'd0,
  parameter int unsigned EDGE_TYPE   = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  localparam logic [2:0] A_DATA = 3'd0;
  localparam logic [2:0] A_MASK = 3'd2;
  localparam logic [2:0] A_ECAP = 3'd3;
`ifdef PIO_BITSET_EN
  localparam logic [2:0] A_SET  = 3'd4;
  localparam logic [2:0] A_CLR  = 3'd5;
`endif

  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_ecap;
  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_sync3;
  logic             r_irq;

  logic             w_wr;
  logic [WIDTH-1:0] w_wdat;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_data_nxt;
  logic [31:0]      w_rd;
  logic             w_unused;

  assign w_wr     = chipselect & ~write_n;
  assign w_wdat   = writedata[WIDTH-1:0];
  assign w_unused = ^writedata;

  always_comb begin
    if (EDGE_TYPE == 0)
      w_edge = r_sync2 & ~r_sync3;
    else if (EDGE_TYPE == 1)
      w_edge = ~r_sync2 & r_sync3;
    else
      w_edge = r_sync2 ^ r_sync3;
  end

  assign w_clr = (w_wr && address == A_ECAP) ? w_wdat : '0;

  always_comb begin
    w_data_nxt = r_data;
    if (w_wr && address == A_DATA)
      w_data_nxt = w_wdat;
`ifdef PIO_BITSET_EN
    else if (w_wr && address == A_SET)
      w_data_nxt = r_data | w_wdat;
    else if (w_wr && address == A_CLR)
      w_data_nxt = r_data & ~w_wdat;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data  <= RESET_VALUE[WIDTH-1:0];
      r_mask  <= '0;
      r_ecap  <= '0;
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_sync3 <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_data  <= w_data_nxt;
      if (w_wr && address == A_MASK)
        r_mask <= w_wdat;
      // set wins over a same-cycle clear
      r_ecap  <= (r_ecap & ~w_clr) | w_edge;
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_irq   <= |(r_ecap & r_mask);
    end
  end

  always_comb begin
    w_rd = '0;
    unique case (address)
      A_DATA:  w_rd[WIDTH-1:0] = r_sync2;
      A_MASK:  w_rd[WIDTH-1:0] = r_mask;
      A_ECAP:  w_rd[WIDTH-1:0] = r_ecap;
      default: w_rd = '0;
    endcase
  end

  assign readdata = w_rd;
  assign out_port = r_data;
  assign irq      = r_irq;

endmodule

// File: tb/tb_soc_system_pio_ctrl.sv
// Directed bench for soc_system_pio_ctrl: vector table plus
// hand sequences for edge latency, collisions, masking and reset.
module tb_soc_system_pio_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [7:0]  in_port = 8'h00;
  logic [7:0]  out_port;
  logic        irq;

  int n_chk = 0;
  int n_fail = 0;

  soc_system_pio_ctrl #(
    .WIDTH(8),
    .RESET_VALUE(32'h0000_00A5),
    .EDGE_TYPE(0)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .in_port(in_port),
    .out_port(out_port),
    .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cs;
    logic        wn;
    logic [2:0]  a;
    logic [31:0] wd;
    logic [7:0]  inp;
    logic [7:0]  eout;
    logic [31:0] erd;
    logic        eirq;
  } vec_t;

  vec_t v [15];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    tick();
    write_n    = 1'b1;
  endtask

  logic [7:0] exp_set;
  logic [7:0] exp_clr;

  initial begin
`ifdef PIO_BITSET_EN
    exp_set = 8'hFF;
    exp_clr = 8'hFC;
`else
    exp_set = 8'h0F;
    exp_clr = 8'h0F;
`endif
    //       cs    wn    a     wd            in     out      rd            irq
    v[0]  = '{1'b1, 1'b0, 3'd0, 32'h12345678, 8'h00, 8'h78,   32'h0,        1'b0};
    v[1]  = '{1'b1, 1'b1, 3'd0, 32'h0,        8'h3C, 8'h78,   32'h0,        1'b0};
    v[2]  = '{1'b1, 1'b1, 3'd0, 32'h0,        8'h3C, 8'h78,   32'h3C,       1'b0};
    v[3]  = '{1'b1, 1'b1, 3'd3, 32'h0,        8'h3C, 8'h78,   32'h3C,       1'b0};
    v[4]  = '{1'b1, 1'b0, 3'd2, 32'hFFFFFF04, 8'h3C, 8'h78,   32'h04,       1'b0};
    v[5]  = '{1'b1, 1'b1, 3'd2, 32'h0,        8'h3C, 8'h78,   32'h04,       1'b1};
    v[6]  = '{1'b1, 1'b0, 3'd3, 32'h000000FF, 8'h3C, 8'h78,   32'h0,        1'b1};
    v[7]  = '{1'b1, 1'b1, 3'd3, 32'h0,        8'h3C, 8'h78,   32'h0,        1'b0};
    v[8]  = '{1'b1, 1'b0, 3'd1, 32'hFFFFFFFF, 8'h3C, 8'h78,   32'h0,        1'b0};
    v[9]  = '{1'b1, 1'b0, 3'd7, 32'hFFFFFFFF, 8'h3C, 8'h78,   32'h0,        1'b0};
    v[10] = '{1'b1, 1'b0, 3'd2, 32'h0,        8'h3C, 8'h78,   32'h0,        1'b0};
    v[11] = '{1'b1, 1'b0, 3'd0, 32'h0000000F, 8'h3C, 8'h0F,   32'h3C,       1'b0};
    v[12] = '{1'b1, 1'b0, 3'd4, 32'h000000F0, 8'h3C, exp_set, 32'h0,        1'b0};
    v[13] = '{1'b1, 1'b0, 3'd5, 32'h00000003, 8'h3C, exp_clr, 32'h0,        1'b0};
    v[14] = '{1'b0, 1'b0, 3'd0, 32'h000000AA, 8'h3C, exp_clr, 32'h3C,       1'b0};

    // reset asserted between clock edges, checked before any edge
    #2 reset_n = 1'b0;
    #1;
    chk("rst_out", {24'd0, out_port}, 32'hA5);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    address = 3'd2; #1;
    chk("rst_mask", readdata, 32'd0);
    address = 3'd3; #1;
    chk("rst_ecap", readdata, 32'd0);
    tick();
    tick();
    reset_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      chipselect = v[i].cs;
      write_n    = v[i].wn;
      address    = v[i].a;
      writedata  = v[i].wd;
      in_port    = v[i].inp;
      tick();
      chk($sformatf("v%0d_out", i), {24'd0, out_port}, {24'd0, v[i].eout});
      chk($sformatf("v%0d_rd", i), readdata, v[i].erd);
      chk($sformatf("v%0d_irq", i), {31'd0, irq}, {31'd0, v[i].eirq});
    end
    chipselect = 1'b1;
    write_n    = 1'b1;

    // rising edge on bit 0: capture latency and irq
    wr(3'd2, 32'h01);
    address = 3'd3;
    in_port = 8'h3D;
    tick();
    tick();
    chk("edge_early", readdata, 32'h0);
    tick();
    chk("edge_cap", readdata, 32'h01);
    chk("edge_irq0", {31'd0, irq}, 32'd0);
    tick();
    chk("edge_irq1", {31'd0, irq}, 32'd1);
    wr(3'd3, 32'h01);
    address = 3'd3;
    chk("ecap_clr", readdata, 32'h0);
    tick();
    chk("irq_clr", {31'd0, irq}, 32'd0);

    // falling edge ignored, then set/clear collision on bit 2
    in_port = 8'h39;
    tick(); tick(); tick();
    chk("fall_ign", readdata, 32'h0);
    in_port = 8'h3D;
    tick();
    tick();
    wr(3'd3, 32'h04);
    address = 3'd3;
    chk("collide", readdata, 32'h04);
    wr(3'd3, 32'h04);
    address = 3'd3;
    chk("clr_b2", readdata, 32'h0);

    // masked capture and reserved address
    in_port = 8'hBD;
    tick(); tick(); tick();
    chk("cap_b7", readdata, 32'h80);
    wr(3'd2, 32'h7F);
    tick();
    chk("mask_irq", {31'd0, irq}, 32'd0);
    wr(3'd1, 32'hFFFFFFFF);
    address = 3'd1; #1;
    chk("rsv_rd", readdata, 32'h0);
    address = 3'd3; #1;
    chk("rsv_ecap", readdata, 32'h80);
    address = 3'd2; #1;
    chk("rsv_mask", readdata, 32'h7F);
    wr(3'd2, 32'hFF);
    tick();
    chk("unmask_irq", {31'd0, irq}, 32'd1);

    // reset mid-cycle with live state
    reset_n = 1'b0;
    #1;
    chk("rst2_out", {24'd0, out_port}, 32'hA5);
    chk("rst2_irq", {31'd0, irq}, 32'd0);
    address = 3'd2; #1;
    chk("rst2_mask", readdata, 32'h0);
    address = 3'd3; #1;
    chk("rst2_ecap", readdata, 32'h0);
    address = 3'd0; #1;
    chk("rst2_data", readdata, 32'h0);

    // release with in_port=0: no spurious edge; write during reset dropped
    in_port   = 8'h00;
    write_n   = 1'b0;
    writedata = 32'h55;
    tick();
    write_n = 1'b1;
    reset_n = 1'b1;
    address = 3'd3;
    tick(); tick(); tick(); tick();
    chk("rel0_ecap", readdata, 32'h0);
    chk("rel0_out", {24'd0, out_port}, 32'hA5);

    // release with in_port=1 yields a rising capture
    reset_n = 1'b0;
    in_port = 8'h01;
    tick(); tick();
    reset_n = 1'b1;
    tick(); tick();
    chk("rel1_early", readdata, 32'h0);
    tick();
    chk("rel1_ecap", readdata, 32'h01);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/soc_system_pio_ctrl.md
SOC_SYSTEM_PIO_CTRL -- requirements
Module: soc_system_pio_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8: out_port/in_port width, legal 1..32.
REQ-002 SHALL have parameter RESET_VALUE, default 0: out_port value after reset (low WIDTH bits used).
REQ-003 SHALL have parameter EDGE_TYPE, default 0: capture edge, 0 rising, 1 falling, 2 any.
REQ-004 SHALL have port clk  input  1  single clock; all state on posedge clk.
REQ-005 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port address  input  3  Avalon-MM word address.
REQ-007 SHALL have port chipselect  input  1  slave select.
REQ-008 SHALL have port write_n  input  1  active-low write strobe.
REQ-009 SHALL have port writedata  input  32  write data.
REQ-010 SHALL have port readdata  output  32  read data, zero-wait, combinational from address.
REQ-011 SHALL have port in_port  input  WIDTH  asynchronous external inputs.
REQ-012 SHALL have port out_port  output  WIDTH  registered outputs.
REQ-013 SHALL have port irq  output  1  level interrupt, active high.

Function
REQ-014 SHALL register map: 0 DATA, 2 IRQMASK, 3 EDGECAP, 4 OUTSET, 5 OUTCLR; addresses 1, 6, 7 read 0, writes ignored.
REQ-015 SHALL treat write as chipselect=1 and write_n=0 in a cycle; register updates visible the next cycle.
REQ-016 SHALL on DATA write load data_out <= writedata[WIDTH-1:0]; out_port = data_out.
REQ-017 SHALL on DATA read return out-of-synchroniser in_port value (sync2), zero-extended to 32 bits.
REQ-018 SHALL synchronise in_port through two flops (sync1, sync2) plus one history flop (sync3); in_port change visible in DATA read 2 cycles later.
REQ-019 SHALL detect per-bit edge: rising = sync2&~sync3, falling = ~sync2&sync3, any = sync2^sync3, per EDGE_TYPE.
REQ-020 SHALL set EDGECAP bit on detected edge; bit holds until cleared; edge-to-EDGECAP latency 3 cycles from in_port change.
REQ-021 SHALL clear EDGECAP bits where writedata bit=1 on EDGECAP write; writedata 0 bits unaffected.
REQ-022 SHALL give set priority: same-cycle edge and clear on one bit leaves bit = 1.
REQ-023 SHALL load IRQMASK <= writedata[WIDTH-1:0] on write; read returns it zero-extended.
REQ-024 SHALL drive irq = |(EDGECAP & IRQMASK), registered (1 cycle after EDGECAP/IRQMASK change).
REQ-025 SHALL return 0 for bits [31:WIDTH] of every read.

Reset
REQ-026 SHALL on reset_n=0, asynchronously: data_out=RESET_VALUE, IRQMASK=0, EDGECAP=0, sync1/2/3=0, irq=0.
REQ-027 SHALL not detect a spurious edge from reset values of sync flops on first cycles after release when in_port=0; in_port=1 at release yields a rising edge (documented behaviour).
REQ-028 SHALL abort any in-progress write on reset; no register retains a partial update.

Configuration
REQ-029 SHALL with PIO_BITSET_EN defined: OUTSET write does data_out |= writedata, OUTCLR write does data_out &= ~writedata; both read 0.
REQ-030 SHALL without PIO_BITSET_EN: addresses 4, 5 behave as reserved (writes ignored, read 0); no set/clear logic synthesised.

Verification
REQ-031 SHALL cover reset: WIDTH=8, RESET_VALUE=8'hA5, reset_n low mid-cycle -> out_port=8'hA5, irq=0, all reads of 2/3 = 0 immediately.
REQ-032 SHALL cover DATA: write 32'h1234_5678 to addr 0 -> out_port=8'h78 next cycle; in_port=8'h3C -> DATA read = 32'h0000_003C after 2 cycles.
REQ-033 SHALL cover edge/irq: EDGE_TYPE=0, IRQMASK=8'h01, in_port[0] 0->1 -> EDGECAP=8'h01 after 3 cycles, irq=1 one cycle later; write 8'h01 to addr 3 -> irq=0.
REQ-034 SHALL cover collision: rising edge on bit 2 in same cycle as EDGECAP clear of 8'h04 -> EDGECAP[2] stays 1.
REQ-035 SHALL cover bit-set: PIO_BITSET_EN defined, out_port=8'h0F, write 8'hF0 to addr 4 then 8'h03 to addr 5 -> out_port 8'hFF then 8'hFC; undefined -> out_port stays 8'h0F.
REQ-036 SHALL cover masking/reserved: EDGECAP=8'h80, IRQMASK=8'h7F -> irq=0; write to addr 1 -> no state change, read 0.
